// File: rtl/bus_arbiter_mux.sv
// Registered N-to-1 bus multiplexer with round-robin arbitration, a forced-select override and a valid/ready output.
// Define BUS_MUX_PARITY_EN to add a registered even-parity output (bus_parity_o).
module bus_arbiter_mux #(
  parameter int WIDTH   = 16,
  parameter int NUM_SRC = 16,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_SRC*WIDTH-1:0] src_data_i,
  input  logic [NUM_SRC-1:0]       src_req_i,
  input  logic                     force_en_i,
  input  logic [SEL_W-1:0]         force_sel_i,
  input  logic                     bus_ready_i,
  output logic                     bus_valid_o,
  output logic [WIDTH-1:0]         bus_data_o,
  output logic [NUM_SRC-1:0]       grant_o,
`ifdef BUS_MUX_PARITY_EN
  output logic                     bus_parity_o,
`endif
  output logic [SEL_W-1:0]         grant_id_o
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   last_ptr_q;
  logic [SEL_W-1:0]   gid_q;
  logic [WIDTH-1:0]   data_q;
  logic [NUM_SRC-1:0] grant_q;
  logic [SEL_W-1:0]   cand;
  logic               has_cand;
  logic               load_ok;
  logic               load;
  logic [WIDTH-1:0]   cand_word;

  // Candidate pick: forced index wins; otherwise first requester after last_ptr, wrapping.
  always_comb begin
    int idx;
    idx      = 0;
    cand     = '0;
    has_cand = 1'b0;
    if (force_en_i) begin
      if (int'(force_sel_i) < NUM_SRC) begin
        has_cand = 1'b1;
        cand     = force_sel_i;
      end
    end else begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        idx = (int'(last_ptr_q) + k) % NUM_SRC;
        if (!has_cand && src_req_i[idx]) begin
          has_cand = 1'b1;
          cand     = SEL_W'(idx);
        end
      end
    end
  end

  assign cand_word = src_data_i[int'(cand)*WIDTH +: WIDTH];

  always_comb begin
    state_d = state_q;
    load_ok = (state_q == EMPTY) || bus_ready_i;
    load    = load_ok && has_cand;
    case (state_q)
      EMPTY:   if (has_cand) state_d = FULL;
      FULL:    if (bus_ready_i) state_d = has_cand ? FULL : EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // grant is a one-cycle pulse; word, id and pointer only move on a load.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q     <= '0;
      gid_q      <= '0;
      grant_q    <= '0;
      last_ptr_q <= SEL_W'(NUM_SRC - 1);
    end else begin
      grant_q <= '0;
      if (load) begin
        data_q  <= cand_word;
        gid_q   <= cand;
        grant_q <= NUM_SRC'(1) << cand;
        if (!force_en_i) last_ptr_q <= cand;
      end
    end
  end

`ifdef BUS_MUX_PARITY_EN
  logic parity_q;
  always_ff @(posedge clk_i) begin
    if (rst_i)     parity_q <= 1'b0;
    else if (load) parity_q <= ^cand_word;
  end
  assign bus_parity_o = parity_q;
`endif

  assign bus_valid_o = (state_q == FULL);
  assign bus_data_o  = data_q;
  assign grant_o     = grant_q;
  assign grant_id_o  = gid_q;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed + randomized bench for bus_arbiter_mux against a distance-based round-robin reference model.
module tb_bus_arbiter_mux;
  localparam int W = 16;
  localparam int N = 16;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*W-1:0]  src_data;
  logic [N-1:0]    src_req;
  logic            force_en;
  logic [SW-1:0]   force_sel;
  logic            bus_ready;
  logic            bus_valid;
  logic [W-1:0]    bus_data;
  logic [N-1:0]    grant;
  logic [SW-1:0]   grant_id;
`ifdef BUS_MUX_PARITY_EN
  logic            bus_parity;
`endif

  logic [W-1:0] src [N];

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int           m_last;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic [N-1:0] m_grant;
  int           m_gid;

  bus_arbiter_mux #(.WIDTH(W), .NUM_SRC(N)) dut (
    .clk_i(clk), .rst_i(rst), .src_data_i(src_data), .src_req_i(src_req),
    .force_en_i(force_en), .force_sel_i(force_sel), .bus_ready_i(bus_ready),
    .bus_valid_o(bus_valid), .bus_data_o(bus_data), .grant_o(grant),
`ifdef BUS_MUX_PARITY_EN
    .bus_parity_o(bus_parity),
`endif
    .grant_id_o(grant_id)
  );

  always #5 clk = ~clk;

  always_comb begin
    src_data = '0;
    for (int i = 0; i < N; i++) src_data[i*W +: W] = src[i];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Winner = requester with the smallest forward distance from last grant.
  task automatic model_step();
    int c, bestd, d;
    if (rst) begin
      m_valid = 0; m_data = '0; m_grant = '0; m_gid = 0; m_last = N - 1;
      return;
    end
    if (m_valid && !bus_ready) begin
      m_grant = '0;
      return;
    end
    c = -1;
    if (force_en) begin
      if (int'(force_sel) < N) c = int'(force_sel);
    end else begin
      bestd = N + 1;
      for (int i = 0; i < N; i++) begin
        d = (i - m_last - 1 + 2*N) % N;
        if (src_req[i] && d < bestd) begin bestd = d; c = i; end
      end
    end
    if (c >= 0) begin
      m_valid = 1; m_data = src[c]; m_gid = c; m_grant = '0; m_grant[c] = 1'b1;
      if (!force_en) m_last = c;
    end else begin
      m_valid = 0; m_grant = '0;
    end
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, 32'(bus_valid), 32'(m_valid));
    chk({tag, ".data"},  32'(bus_data),  32'(m_data));
    chk({tag, ".grant"}, 32'(grant),     32'(m_grant));
    chk({tag, ".gid"},   32'(grant_id),  32'(m_gid));
`ifdef BUS_MUX_PARITY_EN
    chk({tag, ".par"},   32'(bus_parity), 32'(^m_data));
`endif
  endtask

  initial begin
    rst = 1; force_en = 0; force_sel = '0; bus_ready = 1; src_req = '1;
    for (int i = 0; i < N; i++) src[i] = 16'h1000 + 16'(i);

    // reset with every source requesting
    cycle("rst0");
    chk("rst0.valid_c", 32'(bus_valid), 0);
    chk("rst0.data_c",  32'(bus_data), 0);
    cycle("rst1");
    chk("rst1.grant_c", 32'(grant), 0);
    rst = 0;
    cycle("rel");
    chk("rel.grant_c", 32'(grant), 32'h0001);
    chk("rel.gid_c",   32'(grant_id), 0);

    // round-robin with wrap
    rst = 1; src_req = 16'h8005;
    cycle("rr_rst");
    rst = 0;
    cycle("rr0"); chk("rr0.data_c", 32'(bus_data), 32'h1000);
    cycle("rr1"); chk("rr1.data_c", 32'(bus_data), 32'h1002);
    cycle("rr2"); chk("rr2.data_c", 32'(bus_data), 32'h100F);
    cycle("rr3"); chk("rr3.data_c", 32'(bus_data), 32'h1000);
    chk("rr3.gid_c", 32'(grant_id), 0);

    // stall holds the word despite source change and new request
    src[3] = 16'hBEEF; src_req = 16'h0008;
    cycle("st_ld"); chk("st_ld.data_c", 32'(bus_data), 32'hBEEF);
    bus_ready = 0; src[3] = 16'h0000; src_req = 16'h0028;
    for (int i = 0; i < 4; i++) cycle("stall");
    chk("stall.data_c",  32'(bus_data), 32'hBEEF);
    chk("stall.grant_c", 32'(grant), 0);
    bus_ready = 1;
    cycle("st_rel"); chk("st_rel.data_c", 32'(bus_data), 32'h1005);

    // forced select, pointer untouched
    force_en = 1; force_sel = 4'd9; src_req = '0; src[9] = 16'h1234;
    cycle("frc");
    chk("frc.data_c",  32'(bus_data), 32'h1234);
    chk("frc.grant_c", 32'(grant), 32'h0200);
    force_en = 0; src_req = 16'h0003;
    cycle("frc_rr"); chk("frc_rr.gid_c", 32'(grant_id), 0);

    // drain
    src_req = '0;
    cycle("drain");
    chk("drain.valid_c", 32'(bus_valid), 0);
    chk("drain.data_c",  32'(bus_data), 32'h1000);

`ifdef BUS_MUX_PARITY_EN
    force_en = 1; force_sel = 4'd7; src[7] = 16'h0007;
    cycle("par7"); chk("par7.par_c", 32'(bus_parity), 1);
    src[7] = 16'h0003;
    cycle("par3"); chk("par3.par_c", 32'(bus_parity), 0);
    force_en = 0;
`endif

    // randomized traffic
    for (int t = 0; t < 400; t++) begin
      rst       = ($urandom_range(99) < 2);
      force_en  = ($urandom_range(9) == 0);
      force_sel = SW'($urandom_range(N - 1));
      bus_ready = ($urandom_range(3) != 0);
      src_req   = N'($urandom) & N'($urandom);
      for (int i = 0; i < N; i++) src[i] = W'($urandom);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/bus_arbiter_mux.md
# bus_arbiter_mux

Parametrised, registered successor to the 16-to-1 register-to-bus multiplexer. It selects one of `NUM_SRC` register outputs onto the shared data bus, either by a direct select (legacy mode) or by round-robin arbitration among requesting sources. The result is presented through a registered valid/ready handshake. It sits between the register file outputs and the internal bus consumer (ALU operand latch or memory write port).

## Interface

**Parameters**

- `WIDTH`, 16: bus and source data width in bits.
- `NUM_SRC`, 16: number of sources, at least 2.
- `SEL_W`, `$clog2(NUM_SRC)`: select and grant-ID width. Derived; do not override.

**Ports**

One clock; reset is synchronous and active-high.

- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `src_data` input `NUM_SRC*WIDTH`: flattened source data. Source i occupies bits `[i*WIDTH +: WIDTH]`.
- `src_req` input `NUM_SRC`: per-source request, level-sensitive.
- `force_en` input 1: direct-select mode enable.
- `force_sel` input `SEL_W`: source index used when `force_en`=1.
- `bus_ready` input 1: consumer accepts `bus_data` this cycle.
- `bus_valid` output 1: `bus_data` holds a valid word.
- `bus_data` output `WIDTH`: registered selected word.
- `grant` output `NUM_SRC`: one-hot, one-cycle pulse marking the source loaded this cycle.
- `grant_id` output `SEL_W`: index of the source currently held in `bus_data`.
- `bus_parity` output 1: present only with `BUS_MUX_PARITY_EN`.

## Operation

- **Slot free condition:** `load_ok = !bus_valid || bus_ready`.
- **Candidate selection**, evaluated every cycle:
  - If `force_en`=1, the candidate is `force_sel`, regardless of `src_req`.
  - If `force_en`=1 and `force_sel` ≥ `NUM_SRC`, there is no candidate.
  - Otherwise, the candidate is the first i with `src_req[i]`=1, scanning upward from `(last_ptr+1) mod NUM_SRC` with wrap-around.
- **On a `load_ok` edge with a candidate c:**
  - `bus_data` ← source c.
  - `bus_valid` ← 1.
  - `grant_id` ← c.
  - `grant` ← one-hot(c).
- **Pointer update:** `last_ptr` ← c only in arbitration mode. Forced loads leave `last_ptr` unchanged.
- **On a `load_ok` edge with no candidate:** `bus_valid` ← 0, `grant` ← 0. `bus_data` and `grant_id` hold their values.
- **Stall** (`bus_valid`=1 and `bus_ready`=0):
  - `bus_data`, `grant_id` and `last_ptr` hold.
  - `grant` = 0.
  - Source data changes are ignored.
- **Behavioural states:**
  - EMPTY (`bus_valid`=0) → FULL on a candidate.
  - FULL → FULL on accept plus candidate (back-to-back transfer).
  - FULL → EMPTY on accept with no candidate.
  - FULL → FULL, holding, on a stall.
- **Requesters:** a source is not required to drop `src_req` after being granted. A source that keeps requesting is re-granted only after every other requester has been served once.
- **Reset mid-transfer:** a word held in `bus_data` is discarded without a handshake.

## Timing

- **Latency:** a request or select sampled on edge N appears on `bus_data` and `bus_valid` after edge N. One cycle, registered; there are no combinational paths from inputs to outputs.
- **Throughput:** one word per cycle while `bus_ready`=1 and a candidate exists.
- **`grant`:** asserts in the same cycle that the new word is first valid.
- **Reset values:**
  - `bus_valid`=0
  - `bus_data`=0
  - `grant`=0
  - `grant_id`=0
  - `last_ptr`=`NUM_SRC-1`, so source 0 has first priority.
  - `bus_parity`=0
- **Reset precedence:** `rst` overrides all other inputs on the same edge.
- **`force_en` toggling:** takes effect at the next `load_ok` edge. It never corrupts a held word.

## Configuration

- **`BUS_MUX_PARITY_EN` defined:**
  - Adds the `bus_parity` output, registered together with `bus_data`: `bus_parity` = ^`bus_data` (even parity).
  - `bus_parity` holds during a stall and resets to 0.
- **`BUS_MUX_PARITY_EN` undefined:**
  - The `bus_parity` port and its logic are absent.
  - All other behaviour is identical.

## Test plan

All scenarios use the defaults: `WIDTH`=16, `NUM_SRC`=16.

- **Reset.** Assert `rst` for 2 cycles with all `src_req`=1 → `bus_valid`=0, `bus_data`=0x0000, `grant`=0 throughout. On the first cycle after release, `grant_id`=0 and `grant`=0x0001.
- **Round-robin fairness.** Hold `src_req`=0x8005, `bus_ready`=1, source i data = 0x1000+i → words 0x1000, 0x1002, 0x100F, 0x1000 on consecutive cycles, with `grant_id` 0, 2, 15, 0 (wrap).
- **Stall.** Load source 3 (0xBEEF), then hold `bus_ready`=0 for 4 cycles while changing source 3 to 0x0000 and raising `src_req[5]` → `bus_data` stays 0xBEEF and `grant`=0. After `bus_ready`=1, the next word is source 5's data.
- **Direct mode.** `force_en`=1, `force_sel`=9, `src_req`=0, source 9 = 0x1234 → after one cycle `bus_valid`=1, `bus_data`=0x1234, `grant`=0x0200. Then set `force_en`=0 with `src_req`=0x0003 → source 0 is granted next, since `last_ptr` was unchanged.
- **Drain.** With `bus_valid`=1, set `src_req`=0 and `bus_ready`=1 → `bus_valid`=0 on the next cycle and `bus_data` holds its last value.
- **Parity.** With `BUS_MUX_PARITY_EN`, load 0x0007 → `bus_parity`=1; load 0x0003 → `bus_parity`=0.
